dll_tlp_framer: RTL

DLL_TLP_FRAMER -- requirements
Module: dll_tlp_framer

---
 rtl/dll_tlp_framer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dll_tlp_framer.sv
// Data-link-layer TLP framer: prepends a sequence-number header beat, forwards the TLP, appends the LCRC.
// Optional macro FRAMER_SEQ_LOAD_EN adds seq_load/seq_load_val to preload tx_seq.
module dll_tlp_framer #(
  parameter int SEQ_W   = 12,
  parameter int MAX_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FRAMER_SEQ_LOAD_EN
  input  logic             seq_load,
  input  logic [SEQ_W-1:0] seq_load_val,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [SEQ_W-1:0] tx_seq,
  output logic             frame_err
);

  localparam int               CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);
  localparam logic [31:0]      CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, DROP} state_t;

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] tx_seq_q, tx_seq_d;
  logic [31:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cap_data_q, cap_data_d;
  logic             cap_eop_q, cap_eop_d;
  logic             cap_valid_q, cap_valid_d;
  logic             null_q, null_d;
  logic             err_q, err_d;
  logic             seq_inc_s;
  logic             in_ready_s, out_valid_s, out_sop_s, out_eop_s;
  logic [31:0]      out_data_s;
  logic             beat_eop_s, beat_sop_s;
  logic [31:0]      hdr_word_s;

  // MSB-first CRC-32 update over one dword (first byte on the wire is data[31:24])
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign hdr_word_s = {16'(tx_seq_q), 16'h0000};

  // Next-state and handshake logic
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    cap_data_d  = cap_data_q;
    cap_eop_d   = cap_eop_q;
    cap_valid_d = cap_valid_q;
    null_d      = null_q;
    err_d       = 1'b0;
    seq_inc_s   = 1'b0;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = 32'h0000_0000;
    out_sop_s   = 1'b0;
    out_eop_s   = 1'b0;
    beat_eop_s  = 1'b0;
    beat_sop_s  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid && in_sop) begin
          cap_data_d  = in_data;
          cap_eop_d   = in_eop;
          cap_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = HDR;
        end else if (in_valid) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
      end
      HDR: begin
        out_valid_s = 1'b1;
        out_sop_s   = 1'b1;
        out_data_s  = hdr_word_s;
        if (out_ready) begin
          crc_d   = crc32_step(crc_q, hdr_word_s);
          state_d = DATA;
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        // The beat captured in IDLE goes out before the live input is opened up
        if (cap_valid_q) begin
          out_valid_s = 1'b1;
          out_data_s  = cap_data_q;
          beat_eop_s  = cap_eop_q;
        end else begin
          out_valid_s = in_valid;
          in_ready_s  = out_ready;
          out_data_s  = in_data;
          beat_eop_s  = in_eop;
          beat_sop_s  = in_sop;
        end
        if (out_valid_s && out_ready) begin
          cap_valid_d = 1'b0;
          crc_d       = crc32_step(crc_q, out_data_s);
          cnt_d       = cnt_q + CNT_W'(1'b1);
          err_d       = beat_sop_s;
          if (beat_eop_s) begin
            state_d = CRC;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            null_d  = 1'b1;
            state_d = CRC;
          end else begin
            state_d = DATA;
          end
        end
      end
      CRC: begin
        out_valid_s = 1'b1;
        out_eop_s   = 1'b1;
        out_data_s  = null_q ? crc_q : ~crc_q;
        if (out_ready) begin
          crc_d  = CRC_INIT;
          null_d = 1'b0;
          if (null_q) begin
            state_d = DROP;
          end else begin
            seq_inc_s = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DROP: begin
        in_ready_s = 1'b1;
        if (in_valid && in_eop) state_d = IDLE;
        else                    state_d = DROP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequence number: a preload overrides the end-of-frame increment
  always_comb begin
    tx_seq_d = tx_seq_q;
`ifdef FRAMER_SEQ_LOAD_EN
    if (seq_load)       tx_seq_d = seq_load_val;
    else if (seq_inc_s) tx_seq_d = tx_seq_q + SEQ_W'(1'b1);
    else                tx_seq_d = tx_seq_q;
`else
    if (seq_inc_s) tx_seq_d = tx_seq_q + SEQ_W'(1'b1);
    else           tx_seq_d = tx_seq_q;
`endif
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_seq_q    <= '0;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
      cap_data_q  <= 32'h0000_0000;
      cap_eop_q   <= 1'b0;
      cap_valid_q <= 1'b0;
      null_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_seq_q    <= tx_seq_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      cap_data_q  <= cap_data_d;
      cap_eop_q   <= cap_eop_d;
      cap_valid_q <= cap_valid_d;
      null_q      <= null_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = out_data_s;
  assign out_sop   = out_sop_s;
  assign out_eop   = out_eop_s;
  assign tx_seq    = tx_seq_q;
  assign frame_err = err_q;

endmodule
